// File: rtl/quadrature_encoder_emulator.sv
// Quadrature encoder emulator: produces A/B/Index waveforms at a commanded
// edge rate and direction, either free-running or for a counted move, and
// keeps a signed position count matching what the downstream decoder sees.
// Optional build macro ENC_ERR_INJECT_EN adds an err_inject input that makes
// the next edge an illegal double-step (A and B toggle together).
module quadrature_encoder_emulator #(
    parameter int COUNTS_PER_REV = 4096,
    parameter int PERIOD_W       = 24,
    parameter int MIN_PERIOD     = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] step_period,
    input  logic                direction,
    input  logic                move_start,
    input  logic [15:0]         move_steps,
    input  logic                load_pos,
    input  logic signed [31:0]  load_value,
`ifdef ENC_ERR_INJECT_EN
    input  logic                err_inject,
`endif
    output logic                enc_a,
    output logic                enc_b,
    output logic                enc_index,
    output logic signed [31:0]  emu_position,
    output logic                busy,
    output logic                move_done
);

    localparam int REV_W = (COUNTS_PER_REV > 1) ? $clog2(COUNTS_PER_REV) : 1;
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(COUNTS_PER_REV - 1);
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_MOVE} state_t;

    state_t              state;
    logic [1:0]          phase;        // 0..3 = S0..S3, Gray-mapped onto A/B
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] timer_next;
    logic [PERIOD_W-1:0] eff_period;
    logic [REV_W-1:0]    rev_cnt;
    logic [REV_W-1:0]    rev_next;
    logic [15:0]         remaining;
    logic [1:0]          phase_next;
    logic                edge_fire;
    logic                inject_now;

`ifdef ENC_ERR_INJECT_EN
    logic err_armed;
    assign inject_now = err_armed;
`else
    assign inject_now = 1'b0;
`endif

    // Effective edge spacing: 0 stops, small nonzero requests clamp up.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        eff_period = step_period;
        if (step_period == '0) begin
            eff_period = '0;
        end else if (step_period < MIN_P) begin
            eff_period = MIN_P;
        end
    end

    // Edge strobe, timer reload and the phase/revolution values an edge produces.
    always_comb begin
        edge_fire  = 1'b0;
        phase_next = phase;
        rev_next   = rev_cnt;
        if ((state == ST_RUN && enable) || state == ST_MOVE) begin
            edge_fire = (timer == PERIOD_W'(1)) && (eff_period != '0);
        end

        // Timer of 0 means a stalled run that restarts once the period is nonzero.
        if (eff_period == '0) begin
            timer_next = '0;
        end else if (timer <= PERIOD_W'(1)) begin
            timer_next = eff_period;
        end else begin
            timer_next = timer - PERIOD_W'(1);
        end

        if (inject_now) begin
            phase_next = phase + 2'd2;
        end else if (direction) begin
            phase_next = phase + 2'd1;
            rev_next   = (rev_cnt == REV_MAX) ? '0 : rev_cnt + REV_W'(1);
        end else begin
            phase_next = phase - 2'd1;
            rev_next   = (rev_cnt == '0) ? REV_MAX : rev_cnt - REV_W'(1);
        end
    end

    // Mode FSM with registered busy/move_done and registered A/B/Index outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state     <= ST_IDLE;
            busy      <= 1'b0;
            move_done <= 1'b0;
            timer     <= '0;
            remaining <= '0;
            phase     <= 2'd0;
            rev_cnt   <= '0;
            enc_a     <= 1'b0;
            enc_b     <= 1'b0;
            enc_index <= 1'b1;
        end else begin
            move_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (move_start && move_steps != '0 && eff_period != '0) begin
                        state     <= ST_MOVE;
                        busy      <= 1'b1;
                        remaining <= move_steps;
                        timer     <= eff_period;
                    end else if (enable && eff_period != '0) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        timer <= eff_period;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer_next;
                    end
                end
                ST_MOVE: begin
                    timer <= timer_next;
                    if (edge_fire) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                            move_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (edge_fire) begin
                phase     <= phase_next;
                rev_cnt   <= rev_next;
                enc_a     <= phase_next[1] ^ phase_next[0];
                enc_b     <= phase_next[1];
                enc_index <= (rev_next == '0);
            end
        end
    end

    // Position count; a load in the same cycle as an edge overrides the step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            emu_position <= '0;
        end else if (load_pos) begin
            emu_position <= load_value;
        end else if (edge_fire && !inject_now) begin
            emu_position <= direction ? emu_position + 32'sd1 : emu_position - 32'sd1;
        end
    end

`ifdef ENC_ERR_INJECT_EN
    // Error-inject flag: armed by a pulse, consumed by the next edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_armed <= 1'b0;
        end else if (edge_fire) begin
            err_armed <= err_inject;
        end else if (err_inject) begin
            err_armed <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Self-checking bench for quadrature_encoder_emulator. A behavioural model
// counts elapsed clocks against the sampled interval and derives A/B/Index
// from a phase number and revolution count; directed steps are followed by
// a randomized stretch and a reset-during-move check.
module tb_quadrature_encoder_emulator;

    localparam int CPR  = 8;
    localparam int PW   = 24;
    localparam int MINP = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                enable = 1'b0;
    logic [PW-1:0]       step_period = '0;
    logic                direction = 1'b0;
    logic                move_start = 1'b0;
    logic [15:0]         move_steps = '0;
    logic                load_pos = 1'b0;
    logic signed [31:0]  load_value = '0;
    logic                err_inject = 1'b0;
    logic                enc_a, enc_b, enc_index, busy, move_done;
    logic signed [31:0]  emu_position;

    quadrature_encoder_emulator #(
        .COUNTS_PER_REV(CPR),
        .PERIOD_W(PW),
        .MIN_PERIOD(MINP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .step_period(step_period),
        .direction(direction),
        .move_start(move_start),
        .move_steps(move_steps),
        .load_pos(load_pos),
        .load_value(load_value),
`ifdef ENC_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .enc_a(enc_a),
        .enc_b(enc_b),
        .enc_index(enc_index),
        .emu_position(emu_position),
        .busy(busy),
        .move_done(move_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 idle, 1 free run, 2 counted move.
    int m_mode, m_elapsed, m_interval, m_rem, m_phase, m_rev, m_edges;
    bit m_done, m_flag;
    logic signed [31:0] m_pos;

    int cyc = 0;
    int last_edge_cyc = 0;
    int last_spacing = 0;
    logic [1:0] prev_ab = 2'b00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int eff_of(input logic [PW-1:0] p);
        if (p == '0) return 0;
        if (int'(p) < MINP) return MINP;
        return int'(p);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_elapsed = 0; m_interval = 0; m_rem = 0;
        m_phase = 0; m_rev = 0; m_edges = 0; m_done = 0; m_flag = 0;
        m_pos = 0;
    endtask

    task automatic model_clock();
        int  e;
        bit  ed;
        bit  inj;
        e  = eff_of(step_period);
        ed = 0;
        m_done = 0;
        if (m_mode == 0) begin
            if (move_start && move_steps != 0 && e != 0) begin
                m_mode = 2; m_rem = int'(move_steps); m_elapsed = 0; m_interval = e;
            end else if (enable && e != 0) begin
                m_mode = 1; m_elapsed = 0; m_interval = e;
            end
        end else if (m_mode == 1 && !enable) begin
            m_mode = 0;
        end else begin
            if (e == 0) begin
                m_interval = 0; m_elapsed = 0;
            end else if (m_interval == 0) begin
                m_interval = e; m_elapsed = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == m_interval) begin
                    ed = 1; m_elapsed = 0; m_interval = e;
                end
            end
        end
        inj = m_flag;
        if (ed) begin
            if (inj) begin
                m_phase = (m_phase + 2) % 4;
            end else begin
                m_phase = direction ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
                m_rev   = direction ? (m_rev + 1) % CPR : (m_rev + CPR - 1) % CPR;
                m_pos   = direction ? m_pos + 1 : m_pos - 1;
                m_edges++;
            end
            if (m_mode == 2) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_mode = 0; m_done = 1;
                end
            end
            m_flag = err_inject;
        end else if (err_inject) begin
            m_flag = 1;
        end
        if (load_pos) m_pos = load_value;
    endtask

    function automatic bit edge_next();
        int e;
        e = eff_of(step_period);
        return (m_mode == 2 || (m_mode == 1 && enable)) && e != 0 &&
               m_interval != 0 && m_elapsed + 1 == m_interval;
    endfunction

    task automatic compare();
        check("enc_a", enc_a, (m_phase == 1 || m_phase == 2));
        check("enc_b", enc_b, (m_phase >= 2));
        check("enc_index", enc_index, (m_rev == 0));
        check("emu_position", emu_position, m_pos);
        check("busy", busy, (m_mode != 0));
        check("move_done", move_done, m_done);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        cyc++;
        #1;
        compare();
        if ({enc_a, enc_b} != prev_ab) begin
            last_spacing  = cyc - last_edge_cyc;
            last_edge_cyc = cyc;
            prev_ab       = {enc_a, enc_b};
        end
    endtask

    task automatic wait_edge_next(input string tag);
        int n;
        n = 0;
        while (!edge_next() && n < 200) begin
            step();
            n++;
        end
        check({tag, "_edge_wait"}, (n < 200), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n       = 1'b1;
        prev_ab       = 2'b00;
        last_edge_cyc = cyc;
    endtask

    initial begin
        logic [1:0]         ab_before;
        logic signed [31:0] pos_before;
        int                 done_cnt;
        bit                 seen9;

        model_reset();
        do_reset();

        // Forward free run at 10 clocks per edge.
        enable = 1'b1; step_period = PW'(10); direction = 1'b1;
        seen9 = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m_edges == 9 && !seen9) begin
                check("pos_after_9th_edge", emu_position, 9);
                seen9 = 1;
            end
        end
        check("saw_9_edges", seen9, 1);
        check("spacing_10", last_spacing, 10);
        check("busy_in_run", busy, 1);

        // Direction flip mid-run at period 8.
        step_period = PW'(8);
        repeat (25) step();
        direction = 1'b0;
        repeat (40) step();
        check("spacing_8", last_spacing, 8);

        // Clamp to minimum period, then stall with period 0.
        step_period = PW'(2);
        repeat (20) step();
        check("spacing_clamped", last_spacing, 4);
        step_period = '0;
        repeat (20) step();
        check("stalled_busy", busy, 1);
        check("stalled_no_edge", (cyc - last_edge_cyc >= 20), 1);
        enable = 1'b0;
        repeat (2) step();

        // Counted move of 5 edges.
        step_period = PW'(6); direction = 1'b1;
        pos_before  = m_pos;
        move_steps  = 16'd5; move_start = 1'b1;
        step();
        move_start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (move_done) done_cnt++;
        end
        check("move_done_once", done_cnt, 1);
        check("move_delta", emu_position, pos_before + 5);

        // Zero-length move does nothing.
        move_steps = 16'd0; move_start = 1'b1;
        step();
        move_start = 1'b0;
        repeat (10) step();
        check("zero_move_idle", busy, 0);

        // Reverse from reset: index drops at the first edge.
        direction = 1'b0;
        do_reset();
        enable = 1'b1; step_period = PW'(4);
        wait_edge_next("rev_first");
        step();
        check("index_drops", enc_index, 0);
        repeat (40) step();

        // Load coincident with an edge.
        wait_edge_next("load");
        ab_before  = {enc_a, enc_b};
        load_pos   = 1'b1;
        load_value = -32'sd1000;
        step();
        load_pos = 1'b0;
        check("load_wins", emu_position, -1000);
        check("load_phase_adv", ({enc_a, enc_b} != ab_before), 1);

`ifdef ENC_ERR_INJECT_EN
        // Injected illegal transition.
        err_inject = 1'b1;
        step();
        err_inject = 1'b0;
        wait_edge_next("inject");
        ab_before  = {enc_a, enc_b};
        pos_before = m_pos;
        step();
        check("inject_a_toggles", enc_a, ~ab_before[1]);
        check("inject_b_toggles", enc_b, ~ab_before[0]);
        check("inject_pos_hold", emu_position, pos_before);
`endif

        // Randomized operation.
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 29) == 0) step_period = PW'($urandom_range(0, 12));
            if ($urandom_range(0, 19) == 0) direction = ~direction;
            move_start = ($urandom_range(0, 39) == 0);
            move_steps = 16'($urandom_range(0, 10));
            load_pos   = ($urandom_range(0, 59) == 0);
            load_value = $urandom;
`ifdef ENC_ERR_INJECT_EN
            err_inject = ($urandom_range(0, 49) == 0);
`endif
            step();
            move_start = 1'b0;
            load_pos   = 1'b0;
            err_inject = 1'b0;
        end

        // Reset asserted in the middle of a counted move.
        enable = 1'b0;
        repeat (2) step();
        step_period = PW'(5); move_steps = 16'd50; move_start = 1'b1;
        step();
        move_start = 1'b0;
        repeat (30) step();
        check("move_in_progress", busy, 1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare();
        check("reset_mid_move_busy", busy, 0);
        check("reset_mid_move_pos", emu_position, 0);
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_reset", move_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
